// File: rtl/te_pll_rx_sequencer.sv
// te_pll_rx_sequencer
// Per-lane timing-engine sequencer. Each lane waits a programmable PLL settling
// time after radio_req, then a programmable RX-arm delay after rx_req, and
// produces the registered qualifiers pllSettled / tArstFs for the downstream
// radio-enable synchronizer stage.
//
// Ports:
//   ck            : clock, rising edge
//   arst          : asynchronous active-high reset
//   settle_cycles : PLL settling delay, latched per lane on entry to SETTLING
//   rx_delay      : RX-arm delay, latched per lane on entry to RX_ARM
//   radio_req     : per-lane radio enable request (level)
//   rx_req        : per-lane RX request (level, qualified by radio_req)
//   pllSettled    : per-lane PLL settled (LOCKED, RX_ARM, RX_ON)
//   tArstFs       : per-lane RX path released (RX_ON)
//   settle_abort  : one-cycle pulse when a lane abandons SETTLING
//   busy          : lane counting (SETTLING or RX_ARM)
module te_pll_rx_sequencer #(
   parameter int unsigned BIT_WIDTH = 2,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                 ck,
   input  logic                 arst,
   input  logic [CNT_W-1:0]     settle_cycles,
   input  logic [CNT_W-1:0]     rx_delay,
   input  logic [BIT_WIDTH-1:0] radio_req,
   input  logic [BIT_WIDTH-1:0] rx_req,
   output logic [BIT_WIDTH-1:0] pllSettled,
   output logic [BIT_WIDTH-1:0] tArstFs,
   output logic [BIT_WIDTH-1:0] settle_abort,
   output logic [BIT_WIDTH-1:0] busy
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLING = 3'd1,
      ST_LOCKED   = 3'd2,
      ST_RX_ARM   = 3'd3,
      ST_RX_ON    = 3'd4
   } state_t;

   state_t               state_q [BIT_WIDTH];
   state_t               state_d [BIT_WIDTH];
   logic [CNT_W-1:0]     cnt_q   [BIT_WIDTH];
   logic [CNT_W-1:0]     cnt_d   [BIT_WIDTH];
   logic [CNT_W-1:0]     tgt_q   [BIT_WIDTH];
   logic [CNT_W-1:0]     tgt_d   [BIT_WIDTH];
   logic [CNT_W-1:0]     tgt_eff [BIT_WIDTH];
   logic [BIT_WIDTH-1:0] pll_d;
   logic [BIT_WIDTH-1:0] tarst_d;
   logic [BIT_WIDTH-1:0] abort_d;
   logic [BIT_WIDTH-1:0] busy_d;

   // A programmed delay of zero behaves as one cycle
   always_comb begin
      for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
         tgt_eff[i] = (tgt_q[i] == '0) ? CNT_W'(1) : tgt_q[i];
      end
   end

   // Next-state, counter and output decode; radio drop > rx drop > count done
   always_comb begin
      for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         tgt_d[i]   = tgt_q[i];
         abort_d[i] = 1'b0;

         unique case (state_q[i])
            ST_IDLE: begin
               if (radio_req[i]) begin
                  state_d[i] = ST_SETTLING;
                  cnt_d[i]   = CNT_W'(1);
                  tgt_d[i]   = settle_cycles;
               end
            end
            ST_SETTLING: begin
               if (!radio_req[i]) begin
                  state_d[i] = ST_IDLE;
                  abort_d[i] = 1'b1;
               end else if (cnt_q[i] == tgt_eff[i]) begin
                  state_d[i] = ST_LOCKED;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            ST_LOCKED: begin
               if (!radio_req[i]) begin
                  state_d[i] = ST_IDLE;
               end else if (rx_req[i]) begin
                  state_d[i] = ST_RX_ARM;
                  cnt_d[i]   = CNT_W'(1);
                  tgt_d[i]   = rx_delay;
               end
            end
            ST_RX_ARM: begin
               if (!radio_req[i]) begin
                  state_d[i] = ST_IDLE;
               end else if (!rx_req[i]) begin
                  state_d[i] = ST_LOCKED;
               end else if (cnt_q[i] == tgt_eff[i]) begin
                  state_d[i] = ST_RX_ON;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            ST_RX_ON: begin
               if (!radio_req[i]) begin
                  state_d[i] = ST_IDLE;
               end else if (!rx_req[i]) begin
                  state_d[i] = ST_LOCKED;
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
            end
         endcase

         pll_d[i]   = (state_d[i] == ST_LOCKED) || (state_d[i] == ST_RX_ARM) ||
                      (state_d[i] == ST_RX_ON);
         tarst_d[i] = (state_d[i] == ST_RX_ON);
         busy_d[i]  = (state_d[i] == ST_SETTLING) || (state_d[i] == ST_RX_ARM);
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
            tgt_q[i]   <= '0;
         end
         pllSettled   <= '0;
         tArstFs      <= '0;
         settle_abort <= '0;
         busy         <= '0;
      end else begin
         for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            tgt_q[i]   <= tgt_d[i];
         end
         pllSettled   <= pll_d;
         tArstFs      <= tarst_d;
         settle_abort <= abort_d;
         busy         <= busy_d;
      end
   end

endmodule

// File: tb/tb_te_pll_rx_sequencer.sv
module tb_te_pll_rx_sequencer;

   logic       ck;
   logic       arst;
   logic [7:0] settle_cycles;
   logic [7:0] rx_delay;
   logic [1:0] radio_req;
   logic [1:0] rx_req;
   logic [1:0] pllSettled;
   logic [1:0] tArstFs;
   logic [1:0] settle_abort;
   logic [1:0] busy;

   int tests;
   int fails;

   te_pll_rx_sequencer #(.BIT_WIDTH(2), .CNT_W(8)) dut (
      .ck            (ck),
      .arst          (arst),
      .settle_cycles (settle_cycles),
      .rx_delay      (rx_delay),
      .radio_req     (radio_req),
      .rx_req        (rx_req),
      .pllSettled    (pllSettled),
      .tArstFs       (tArstFs),
      .settle_abort  (settle_abort),
      .busy          (busy)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // One record = inputs applied before an edge, outputs expected after it
   typedef struct packed {
      logic [1:0] rr;
      logic [1:0] rx;
      logic [7:0] sc;
      logic [7:0] rd;
      logic [1:0] pll;
      logic [1:0] ta;
      logic [1:0] ab;
      logic [1:0] bz;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [1:0] rr, input logic [1:0] rx,
                               input logic [7:0] sc, input logic [7:0] rd,
                               input logic [1:0] pll, input logic [1:0] ta,
                               input logic [1:0] ab, input logic [1:0] bz);
      vec_t v;
      v.rr = rr; v.rx = rx; v.sc = sc; v.rd = rd;
      v.pll = pll; v.ta = ta; v.ab = ab; v.bz = bz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [1:0] pll, input logic [1:0] ta,
                      input logic [1:0] ab, input logic [1:0] bz);
      logic [7:0] got;
      logic [7:0] exp;
      got = {pllSettled, tArstFs, settle_abort, busy};
      exp = {pll, ta, ab, bz};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got pll/ta/ab/busy=%b required=%b", name, got, exp);
      end
   endtask

   task automatic step(input logic [1:0] rr, input logic [1:0] rx,
                       input logic [7:0] sc, input logic [7:0] rd);
      @(negedge ck);
      radio_req     = rr;
      rx_req        = rx;
      settle_cycles = sc;
      rx_delay      = rd;
      @(posedge ck);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      arst = 1'b1;
      radio_req = '0;
      rx_req = '0;
      settle_cycles = '0;
      rx_delay = '0;
      #1;
      chk("reset_state", 2'b00, 2'b00, 2'b00, 2'b00);
      @(negedge ck);
      @(negedge ck);
      arst = 1'b0;

      // Basic settle (5) then RX arm (3) on lane 0
      tbl.push_back(mk(2'b01, 2'b00, 8'd5, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(2'b01, 2'b00, 8'd5, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b01, 2'b00, 8'd5, 8'd3, 2'b01, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 2'b01, 8'd5, 8'd3, 2'b01, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b01, 2'b01, 8'd5, 8'd3, 2'b01, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b01, 2'b01, 8'd5, 8'd3, 2'b01, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b01, 2'b01, 8'd5, 8'd3, 2'b01, 2'b01, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 2'b00, 8'd5, 8'd3, 2'b01, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk(2'b00, 2'b00, 8'd5, 8'd3, 2'b00, 2'b00, 2'b00, 2'b00));
      // Zero programming with rx_req held high
      tbl.push_back(mk(2'b01, 2'b01, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b01, 2'b01, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 2'b01, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b01, 2'b01, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00, 2'b00));
      tbl.push_back(mk(2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));
      // Abort of a 10-cycle settle after 4 busy cycles
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(2'b01, 2'b00, 8'd10, 8'd0, 2'b00, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b00, 2'b00, 8'd10, 8'd0, 2'b00, 2'b00, 2'b01, 2'b00));
      tbl.push_back(mk(2'b00, 2'b00, 8'd10, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));
      // Minimum request on lane 1: one busy cycle then one abort pulse
      tbl.push_back(mk(2'b10, 2'b00, 8'd3, 8'd0, 2'b00, 2'b00, 2'b00, 2'b10));
      tbl.push_back(mk(2'b00, 2'b00, 8'd3, 8'd0, 2'b00, 2'b00, 2'b10, 2'b00));
      tbl.push_back(mk(2'b00, 2'b00, 8'd3, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rr, tbl[i].rx, tbl[i].sc, tbl[i].rd);
         chk($sformatf("vec%0d", i), tbl[i].pll, tbl[i].ta, tbl[i].ab, tbl[i].bz);
      end

      // Re-request after abort: full 10-cycle settle again
      for (int k = 0; k < 10; k++) begin
         step(2'b01, 2'b00, 8'd10, 8'd0);
         chk($sformatf("resettle_busy%0d", k), 2'b00, 2'b00, 2'b00, 2'b01);
      end
      step(2'b01, 2'b00, 8'd10, 8'd0);
      chk("resettle_locked", 2'b01, 2'b00, 2'b00, 2'b00);
      step(2'b00, 2'b00, 8'd10, 8'd0);
      chk("resettle_drop", 2'b00, 2'b00, 2'b00, 2'b00);

      // radio_req and rx_req drop on the RX_ARM completion edge
      step(2'b01, 2'b01, 8'd1, 8'd2);
      chk("coinc_e0", 2'b00, 2'b00, 2'b00, 2'b01);
      step(2'b01, 2'b01, 8'd1, 8'd2);
      chk("coinc_locked", 2'b01, 2'b00, 2'b00, 2'b00);
      step(2'b01, 2'b01, 8'd1, 8'd2);
      chk("coinc_arm1", 2'b01, 2'b00, 2'b00, 2'b01);
      step(2'b01, 2'b01, 8'd1, 8'd2);
      chk("coinc_arm2", 2'b01, 2'b00, 2'b00, 2'b01);
      step(2'b00, 2'b00, 8'd1, 8'd2);
      chk("coinc_drop", 2'b00, 2'b00, 2'b00, 2'b00);
      step(2'b00, 2'b00, 8'd1, 8'd2);
      chk("coinc_after", 2'b00, 2'b00, 2'b00, 2'b00);

      // settle_cycles changed 8 -> 2 mid-count has no effect
      step(2'b01, 2'b00, 8'd8, 8'd0);
      chk("latch_e0", 2'b00, 2'b00, 2'b00, 2'b01);
      for (int k = 1; k < 8; k++) begin
         step(2'b01, 2'b00, 8'd2, 8'd0);
         chk($sformatf("latch_busy%0d", k), 2'b00, 2'b00, 2'b00, 2'b01);
      end
      step(2'b01, 2'b00, 8'd2, 8'd0);
      chk("latch_locked", 2'b01, 2'b00, 2'b00, 2'b00);
      step(2'b00, 2'b00, 8'd2, 8'd0);
      chk("latch_drop", 2'b00, 2'b00, 2'b00, 2'b00);

      // Reset with lane 0 in RX_ON and lane 1 in SETTLING
      step(2'b01, 2'b01, 8'd1, 8'd1);
      step(2'b01, 2'b01, 8'd1, 8'd1);
      step(2'b01, 2'b01, 8'd1, 8'd1);
      step(2'b01, 2'b01, 8'd1, 8'd1);
      chk("rst_pre_rxon", 2'b01, 2'b01, 2'b00, 2'b00);
      step(2'b11, 2'b01, 8'd5, 8'd1);
      chk("rst_pre_l1", 2'b01, 2'b01, 2'b00, 2'b10);
      step(2'b11, 2'b01, 8'd5, 8'd1);
      chk("rst_pre_l1b", 2'b01, 2'b01, 2'b00, 2'b10);
      @(negedge ck);
      #2;
      arst = 1'b1;
      #1;
      chk("rst_async", 2'b00, 2'b00, 2'b00, 2'b00);
      @(posedge ck);
      #1;
      chk("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);
      @(negedge ck);
      arst = 1'b0;
      @(posedge ck);
      #1;
      chk("rst_restart", 2'b00, 2'b00, 2'b00, 2'b11);
      for (int k = 1; k < 5; k++) begin
         step(2'b11, 2'b01, 8'd5, 8'd1);
         chk($sformatf("rst_busy%0d", k), 2'b00, 2'b00, 2'b00, 2'b11);
      end
      step(2'b11, 2'b01, 8'd5, 8'd1);
      chk("rst_locked", 2'b11, 2'b00, 2'b00, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
